instruction_fetch_unit: RTL and testbench

Fetches 24-bit instructions from instruction memory and presents them, with their opcode field and PC, to the decode/control stage through a valid/ready handshake. It drives the address side of the instruction-memory request/acknowledge interface. It accepts PC redirects from the execute stage for taken BEQ branches. It stops fetching when a HALT opcode is captured.

---
 rtl/instruction_fetch_unit.sv | 100 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: drives the instruction-memory request, holds the
// fetched word for decode behind a valid/ready handshake, and stops on HALT.
module instruction_fetch_unit #(
  parameter int unsigned          ADDR_WIDTH  = 8,
  parameter int unsigned          INST_WIDTH  = 24,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [3:0]           HALT_OPCODE = 4'b1111
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  output logic                  IMemReq,
  output logic [ADDR_WIDTH-1:0] IMemAddr,
  input  logic                  IMemAck,
  input  logic [INST_WIDTH-1:0] IMemData,
  output logic [INST_WIDTH-1:0] Instr,
  output logic [3:0]            OPCODE,
  output logic [ADDR_WIDTH-1:0] InstrPc,
  output logic                  InstrValid,
  input  logic                  InstrReady,
  input  logic                  Redirect,
  input  logic [ADDR_WIDTH-1:0] RedirectPc,
  output logic                  Halted
);

  localparam int unsigned OPC_W = 4;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic [INST_WIDTH-1:0]   instr_q;
  logic [ADDR_WIDTH-1:0]   instr_pc_q;
  logic                    instr_valid_q;
  logic                    halted_q;

  logic                    xfer_c;
  logic                    consume_c;
  logic [OPC_W-1:0]        data_opc_c;

  // Request only when the output slot is free or being drained this cycle.
  assign IMemReq    = (state_q == RUN) && !Redirect && (!instr_valid_q || InstrReady);
  assign xfer_c     = IMemReq && IMemAck;
  assign consume_c  = InstrReady && instr_valid_q;
  assign data_opc_c = IMemData[INST_WIDTH-1 -: OPC_W];

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= RUN;
          if (Redirect) begin
            pc_q <= RedirectPc;
          end
        end
        RUN, HALTED: begin
          if (Redirect) begin
            // Flush wins over any same-cycle consume or pending transfer.
            state_q       <= RUN;
            pc_q          <= RedirectPc;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
          end else if (xfer_c) begin
            instr_q       <= IMemData;
            instr_pc_q    <= pc_q;
            instr_valid_q <= 1'b1;
            pc_q          <= ADDR_WIDTH'(pc_q + 1'b1);
            if (data_opc_c == HALT_OPCODE) begin
              state_q  <= HALTED;
              halted_q <= 1'b1;
            end
          end else if (consume_c) begin
            instr_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= BOOT;
        end
      endcase
    end
  end

  assign IMemAddr   = pc_q;
  assign Instr      = instr_q;
  assign OPCODE     = instr_q[INST_WIDTH-1 -: OPC_W];
  assign InstrPc    = instr_pc_q;
  assign InstrValid = instr_valid_q;
  assign Halted     = halted_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a combinational zero-wait
// memory whose acknowledge can be gated off to model wait states.
module tb_instruction_fetch_unit;

  logic        Clock;
  logic        Reset_n;
  logic        IMemReq;
  logic [7:0]  IMemAddr;
  logic        IMemAck;
  logic [23:0] IMemData;
  logic [23:0] Instr;
  logic [3:0]  OPCODE;
  logic [7:0]  InstrPc;
  logic        InstrValid;
  logic        InstrReady;
  logic        Redirect;
  logic [7:0]  RedirectPc;
  logic        Halted;

  logic        ack_en;
  logic [23:0] mem [256];
  int          checks;
  int          errors;

  instruction_fetch_unit dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .IMemReq    (IMemReq),
    .IMemAddr   (IMemAddr),
    .IMemAck    (IMemAck),
    .IMemData   (IMemData),
    .Instr      (Instr),
    .OPCODE     (OPCODE),
    .InstrPc    (InstrPc),
    .InstrValid (InstrValid),
    .InstrReady (InstrReady),
    .Redirect   (Redirect),
    .RedirectPc (RedirectPc),
    .Halted     (Halted)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  assign IMemAck  = IMemReq && ack_en;
  assign IMemData = mem[IMemAddr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    Reset_n    = 1'b0;
    ack_en     = 1'b1;
    InstrReady = 1'b1;
    Redirect   = 1'b0;
    RedirectPc = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 24'h200000 | 24'(i);
    mem[8'h00] = 24'h611234;
    mem[8'h01] = 24'h123456;
    mem[8'h05] = 24'hF00000;
    mem[8'hFF] = 24'h7000FF;

    // Reset state
    tick(); tick();
    chk("rst_req", 32'(IMemReq), 32'h0);
    chk("rst_addr", 32'(IMemAddr), 32'h0);
    chk("rst_instr", 32'(Instr), 32'h0);
    chk("rst_opc", 32'(OPCODE), 32'h0);
    chk("rst_ipc", 32'(InstrPc), 32'h0);
    chk("rst_valid", 32'(InstrValid), 32'h0);
    chk("rst_halt", 32'(Halted), 32'h0);

    // Release: BOOT has no request, RUN requests from the first edge
    Reset_n = 1'b1;
    #1;
    chk("boot_req", 32'(IMemReq), 32'h0);
    tick();
    chk("run_req", 32'(IMemReq), 32'h1);
    chk("run_addr", 32'(IMemAddr), 32'h0);
    tick();
    chk("w0_instr", 32'(Instr), 32'h611234);
    chk("w0_opc", 32'(OPCODE), 32'h6);
    chk("w0_ipc", 32'(InstrPc), 32'h0);
    chk("w0_valid", 32'(InstrValid), 32'h1);
    tick();
    chk("w1_instr", 32'(Instr), 32'h123456);
    chk("w1_opc", 32'(OPCODE), 32'h1);
    chk("w1_ipc", 32'(InstrPc), 32'h1);

    // Back-pressure for three cycles
    InstrReady = 1'b0;
    #1;
    chk("bp_req0", 32'(IMemReq), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_req", 32'(IMemReq), 32'h0);
      chk("bp_instr", 32'(Instr), 32'h123456);
      chk("bp_valid", 32'(InstrValid), 32'h1);
    end
    InstrReady = 1'b1;
    #1;
    chk("bp_resume_req", 32'(IMemReq), 32'h1);
    chk("bp_resume_addr", 32'(IMemAddr), 32'h2);
    tick();
    chk("w2_instr", 32'(Instr), 32'h200002);
    chk("w2_ipc", 32'(InstrPc), 32'h2);

    // Two wait states on the memory acknowledge
    ack_en = 1'b0;
    tick();
    chk("ws1_valid", 32'(InstrValid), 32'h0);
    chk("ws1_req", 32'(IMemReq), 32'h1);
    chk("ws1_addr", 32'(IMemAddr), 32'h3);
    chk("ws1_instr_kept", 32'(Instr), 32'h200002);
    tick();
    chk("ws2_addr", 32'(IMemAddr), 32'h3);
    chk("ws2_req", 32'(IMemReq), 32'h1);
    ack_en = 1'b1;
    tick();
    chk("ws_instr", 32'(Instr), 32'h200003);
    chk("ws_ipc", 32'(InstrPc), 32'h3);
    chk("ws_addr_next", 32'(IMemAddr), 32'h4);

    // Redirect flushes the held word even with InstrReady high
    Redirect   = 1'b1;
    RedirectPc = 8'h40;
    #1;
    chk("rd_req_low", 32'(IMemReq), 32'h0);
    tick();
    Redirect = 1'b0;
    #1;
    chk("rd_valid", 32'(InstrValid), 32'h0);
    chk("rd_req", 32'(IMemReq), 32'h1);
    chk("rd_addr", 32'(IMemAddr), 32'h40);
    chk("rd_instr_kept", 32'(Instr), 32'h200003);
    tick();
    chk("rd_instr", 32'(Instr), 32'h200040);
    chk("rd_ipc", 32'(InstrPc), 32'h40);

    // HALT captured at 0x05
    Redirect   = 1'b1;
    RedirectPc = 8'h05;
    tick();
    Redirect = 1'b0;
    #1;
    chk("h_addr", 32'(IMemAddr), 32'h5);
    tick();
    chk("h_halted", 32'(Halted), 32'h1);
    chk("h_opc", 32'(OPCODE), 32'hF);
    chk("h_ipc", 32'(InstrPc), 32'h5);
    chk("h_req", 32'(IMemReq), 32'h0);
    chk("h_pc", 32'(IMemAddr), 32'h6);
    InstrReady = 1'b0;
    tick();
    chk("h_hold_valid", 32'(InstrValid), 32'h1);
    chk("h_hold_req", 32'(IMemReq), 32'h0);
    InstrReady = 1'b1;
    tick();
    chk("h_cons_valid", 32'(InstrValid), 32'h0);
    chk("h_cons_req", 32'(IMemReq), 32'h0);
    chk("h_cons_halt", 32'(Halted), 32'h1);
    chk("h_cons_pc", 32'(IMemAddr), 32'h6);
    Redirect   = 1'b1;
    RedirectPc = 8'h00;
    tick();
    Redirect = 1'b0;
    #1;
    chk("hr_halted", 32'(Halted), 32'h0);
    chk("hr_req", 32'(IMemReq), 32'h1);
    chk("hr_addr", 32'(IMemAddr), 32'h0);
    tick();
    chk("hr_instr", 32'(Instr), 32'h611234);

    // PC wrap at 0xFF
    Redirect   = 1'b1;
    RedirectPc = 8'hFF;
    tick();
    Redirect = 1'b0;
    #1;
    chk("wr_addr", 32'(IMemAddr), 32'hFF);
    tick();
    chk("wr_instr", 32'(Instr), 32'h7000FF);
    chk("wr_ipc", 32'(InstrPc), 32'hFF);
    chk("wr_next", 32'(IMemAddr), 32'h0);
    tick();
    chk("wr_ipc0", 32'(InstrPc), 32'h0);
    chk("wr_next1", 32'(IMemAddr), 32'h1);

    // Reset during a pending (unacknowledged) request
    ack_en = 1'b0;
    #1;
    chk("pr_req", 32'(IMemReq), 32'h1);
    Reset_n = 1'b0;
    #1;
    chk("pr_valid", 32'(InstrValid), 32'h0);
    chk("pr_addr", 32'(IMemAddr), 32'h0);
    chk("pr_req_low", 32'(IMemReq), 32'h0);
    chk("pr_instr", 32'(Instr), 32'h0);
    ack_en = 1'b1;
    tick();
    Reset_n = 1'b1;
    tick();
    chk("pr_run_req", 32'(IMemReq), 32'h1);
    tick();
    chk("pr_instr0", 32'(Instr), 32'h611234);
    chk("pr_ipc0", 32'(InstrPc), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
